// File: rtl/bus_command_decoder_if.sv
// CPU-side command bus: chip select, write/read strobes, register address and write data.
interface bus_command_decoder_if;
  logic       CS_N;
  logic       WR_N;
  logic       RD_N;
  logic       A0;
  logic [7:0] DATA_BUS;

  modport master (output CS_N, WR_N, RD_N, A0, DATA_BUS);
  modport slave  (input  CS_N, WR_N, RD_N, A0, DATA_BUS);
endinterface

// File: rtl/bus_command_decoder.sv
// Interrupt-controller style command decoder: captures CPU writes, classifies ICW1-4 / OCW1-3,
// tracks the initialization sequence and produces single-cycle command and read pulses.
module bus_command_decoder #(
  parameter bit OCW_GATE = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  bus_command_decoder_if.slave   bus,
  output logic                   ICW1_RECEIVED,
  output logic                   ICW2_RECEIVED,
  output logic                   ICW3_RECEIVED,
  output logic                   ICW4_RECEIVED,
  output logic                   OCW1_RECEIVED,
  output logic                   OCW2_RECEIVED,
  output logic                   OCW3_RECEIVED,
  output logic [7:0]             DATA_OUT,
  output logic                   SNGL,
  output logic                   IC4,
  output logic                   INIT_DONE,
  output logic                   READ_STROBE,
  output logic                   READ_A0
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 7;

  localparam logic [PW-1:0] P_ICW1 = 7'b1000000;
  localparam logic [PW-1:0] P_ICW2 = 7'b0100000;
  localparam logic [PW-1:0] P_ICW3 = 7'b0010000;
  localparam logic [PW-1:0] P_ICW4 = 7'b0001000;
  localparam logic [PW-1:0] P_OCW1 = 7'b0000100;
  localparam logic [PW-1:0] P_OCW2 = 7'b0000010;
  localparam logic [PW-1:0] P_OCW3 = 7'b0000001;

  typedef enum logic [1:0] {
    CMD_READY  = 2'b00,
    WRITE_ICW2 = 2'b01,
    WRITE_ICW3 = 2'b10,
    WRITE_ICW4 = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic          a0_q, a0_d;
  logic [DW-1:0] data_q, data_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          sngl_q, sngl_d;
  logic          ic4_q, ic4_d;
  logic          init_done_q, init_done_d;
  logic          rd_prev_q, rd_prev_d;
  logic          strobe_q, strobe_d;
  logic          read_a0_q, read_a0_d;

  logic wr_cyc_c;
  logic rd_cyc_c;

  assign wr_cyc_c = !bus.CS_N && !bus.WR_N &&  bus.RD_N;
  assign rd_cyc_c = !bus.CS_N && !bus.RD_N &&  bus.WR_N;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= CMD_READY;
      pend_q      <= 1'b0;
      a0_q        <= 1'b0;
      data_q      <= '0;
      pulse_q     <= '0;
      data_out_q  <= '0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      init_done_q <= 1'b0;
      rd_prev_q   <= 1'b0;
      strobe_q    <= 1'b0;
      read_a0_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      a0_q        <= a0_d;
      data_q      <= data_d;
      pulse_q     <= pulse_d;
      data_out_q  <= data_out_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      init_done_q <= init_done_d;
      rd_prev_q   <= rd_prev_d;
      strobe_q    <= strobe_d;
      read_a0_q   <= read_a0_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    a0_d        = a0_q;
    data_d      = data_q;
    pulse_d     = '0;
    data_out_d  = data_out_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    init_done_d = init_done_q;

    // Read strobe fires only on the first cycle of a read; A0 held until the next one.
    rd_prev_d = rd_cyc_c;
    strobe_d  = rd_cyc_c && !rd_prev_q;
    read_a0_d = (rd_cyc_c && !rd_prev_q) ? bus.A0 : read_a0_q;

    if (wr_cyc_c) begin
      pend_d = 1'b1;
      a0_d   = bus.A0;
      data_d = bus.DATA_BUS;
    end else if (!bus.WR_N) begin
      pend_d = 1'b0;
    end else if (pend_q) begin
      pend_d = 1'b0;
      if (!a0_q && data_q[4]) begin
        pulse_d     = P_ICW1;
        data_out_d  = data_q;
        sngl_d      = data_q[1];
        ic4_d       = data_q[0];
        init_done_d = 1'b0;
        state_d     = WRITE_ICW2;
      end else begin
        unique case (state_q)
          WRITE_ICW2: if (a0_q) begin
            pulse_d    = P_ICW2;
            data_out_d = data_q;
            if (!sngl_q) begin
              state_d = WRITE_ICW3;
            end else if (ic4_q) begin
              state_d = WRITE_ICW4;
            end else begin
              state_d     = CMD_READY;
              init_done_d = 1'b1;
            end
          end
          WRITE_ICW3: if (a0_q) begin
            pulse_d    = P_ICW3;
            data_out_d = data_q;
            if (ic4_q) begin
              state_d = WRITE_ICW4;
            end else begin
              state_d     = CMD_READY;
              init_done_d = 1'b1;
            end
          end
          WRITE_ICW4: if (a0_q) begin
            pulse_d     = P_ICW4;
            data_out_d  = data_q;
            state_d     = CMD_READY;
            init_done_d = 1'b1;
          end
          // D4 is known zero here when A0=0; that pattern was claimed by ICW1 above.
          CMD_READY: if (init_done_q || !OCW_GATE) begin
            data_out_d = data_q;
            if (a0_q)          pulse_d = P_OCW1;
            else if (!data_q[3]) pulse_d = P_OCW2;
            else               pulse_d = P_OCW3;
          end
          default: ;
        endcase
      end
    end
  end

  assign ICW1_RECEIVED = pulse_q[6];
  assign ICW2_RECEIVED = pulse_q[5];
  assign ICW3_RECEIVED = pulse_q[4];
  assign ICW4_RECEIVED = pulse_q[3];
  assign OCW1_RECEIVED = pulse_q[2];
  assign OCW2_RECEIVED = pulse_q[1];
  assign OCW3_RECEIVED = pulse_q[0];
  assign DATA_OUT      = data_out_q;
  assign SNGL          = sngl_q;
  assign IC4           = ic4_q;
  assign INIT_DONE     = init_done_q;
  assign READ_STROBE   = strobe_q;
  assign READ_A0       = read_a0_q;

endmodule

// File: doc/bus_command_decoder.md
BUS_COMMAND_DECODER -- requirements
Module: bus_command_decoder

Interface
REQ-001 SHALL have parameter: OCW_GATE, 1, when 1 OCW writes are ignored until INIT_DONE=1; when 0 they decode at any time outside an ICW sequence.
REQ-002 SHALL have port: CLK  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: RESET  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: CS_N, WR_N, RD_N  in  1 each  active-low chip select, write, read; synchronous to CLK.
REQ-005 SHALL have ports: A0  in  1  register address; DATA_BUS  in  8  CPU write data.
REQ-006 SHALL have ports: ICW1_RECEIVED, ICW2_RECEIVED, ICW3_RECEIVED, ICW4_RECEIVED, OCW1_RECEIVED, OCW2_RECEIVED, OCW3_RECEIVED  out  1 each  single-cycle command pulses to control logic.
REQ-007 SHALL have port: DATA_OUT  out  8  last accepted command byte.
REQ-008 SHALL have ports: SNGL, IC4  out  1 each  ICW1 bit1 and bit0, held.
REQ-009 SHALL have ports: INIT_DONE  out  1  initialization complete; READ_STROBE  out  1  single-cycle read pulse; READ_A0  out  1  A0 captured with READ_STROBE.

Function
REQ-010 Write capture: each cycle CS_N=0, WR_N=0, RD_N=1 SHALL latch A0 and DATA_BUS into holding registers and set a pending flag; the last such cycle wins.
REQ-011 Pending SHALL clear without decode if CS_N=1 or RD_N=0 is sampled while WR_N=0 (aborted or conflicting write).
REQ-012 Decode cycle: first cycle WR_N=1 with pending=1; pending clears; the matching pulse and DATA_OUT update SHALL be visible exactly one cycle later; pulses last one cycle.
REQ-013 At most one *_RECEIVED pulse SHALL be high in any cycle.
REQ-014 Classification: A0=0 and D4=1 -> ICW1 in any state; otherwise per state (REQ-015..018).
REQ-015 States: CMD_READY, WRITE_ICW2, WRITE_ICW3, WRITE_ICW4; 2-bit encoding 00/01/10/11.
REQ-016 ICW1 from any state: pulse ICW1, latch SNGL=D1, IC4=D0, INIT_DONE->0, next WRITE_ICW2; an in-progress sequence is discarded.
REQ-017 WRITE_ICW2 with A0=1: pulse ICW2; next WRITE_ICW3 if SNGL=0, else WRITE_ICW4 if IC4=1, else CMD_READY with INIT_DONE->1.
REQ-018 WRITE_ICW3 with A0=1: pulse ICW3; next WRITE_ICW4 if IC4=1, else CMD_READY with INIT_DONE->1. WRITE_ICW4 with A0=1: pulse ICW4, next CMD_READY, INIT_DONE->1.
REQ-019 In WRITE_ICW2/3/4 a non-ICW1 write with A0=0 SHALL be ignored: no pulse, no state change, DATA_OUT unchanged.
REQ-020 CMD_READY, OCW allowed (INIT_DONE=1 or OCW_GATE=0): A0=1 -> OCW1; A0=0, D4=0, D3=0 -> OCW2; A0=0, D4=0, D3=1 -> OCW3.
REQ-021 Ignored writes SHALL leave DATA_OUT unchanged; accepted writes set DATA_OUT to captured byte in the pulse cycle.
REQ-022 INIT_DONE SHALL update in the same cycle as the completing pulse.
REQ-023 READ_STROBE SHALL pulse one cycle after the first cycle with CS_N=0, RD_N=0, WR_N=1 following a cycle where that condition was false; READ_A0 = A0 of that cycle, held until next strobe.
REQ-024 Reads SHALL not affect state, pending flag or DATA_OUT.

Reset
REQ-025 RESET=0 SHALL asynchronously force: state CMD_READY, pending 0, all pulses 0, DATA_OUT 8'h00, SNGL 0, IC4 0, INIT_DONE 0, READ_STROBE 0, READ_A0 0.
REQ-026 A write pending when RESET asserts SHALL be discarded; a WR_N rise after release without a fresh low SHALL produce no pulse.

Verification
REQ-027 Reset: drive RESET=0 mid-run -> all outputs at REQ-025 values immediately, before next CLK edge.
REQ-028 Single mode: A0=0 0x13; A0=1 0x08; A0=1 0x01 -> ICW1, ICW2, ICW4 pulses, no ICW3; SNGL=1, IC4=1; INIT_DONE=1 with ICW4 pulse; DATA_OUT=0x01.
REQ-029 Cascade: A0=0 0x10; A0=1 0x20; A0=1 0x04 -> ICW1, ICW2, ICW3 pulses; INIT_DONE=1 with ICW3 pulse; DATA_OUT=0x04.
REQ-030 OCWs after init: A0=1 0xFB -> OCW1, DATA_OUT=0xFB; A0=0 0x20 -> OCW2; A0=0 0x0B -> OCW3; each pulse one cycle after WR_N rise.
REQ-031 Gating/restart: OCW_GATE=1, A0=1 0xFF before any ICW1 -> no pulse, DATA_OUT=0x00; A0=0 0x13, A0=0 0x17 -> two ICW1 pulses, state WRITE_ICW2, DATA_OUT=0x17.
REQ-032 Abort/conflict: CS_N rises while WR_N low, or RD_N=0 with WR_N=0 -> no pulse; isolated RD_N low with A0=1 -> one READ_STROBE, READ_A0=1.
